// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial borrow subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    // Bit counter width, $clog2(w), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_borrow_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out for a single column.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one column per clock
// through a single full_subtractor_cell. Ready/valid on input, valid/ack on output.
module serial_borrow_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             Start,
    output logic             Ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             Valid,
    input  logic             Ack
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_nxt;
    logic [CW-1:0]    cnt;
    logic             br, br_nxt, d_bit;
    logic             amsb, bmsb;
    logic             bout_q, v_q, z_q;

    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    // New difference bit enters from the MSB side so the LSB lands at bit 0 last.
    assign d_nxt = {d_bit, d_sr[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; results are gated so nothing partial leaks out.
    always_comb begin
        state_nxt = state;
        Ready     = 1'b0;
        Valid     = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                Valid = 1'b1;
                if (Ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        Diff = Valid ? d_sr : '0;
        Bout = Valid & bout_q;
        V    = Valid & v_q;
        Z    = Valid & z_q;
    end

    // Operand/result shift registers, borrow flop, counter and final flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            bout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bin;
                        amsb <= A[WIDTH-1];
                        bmsb <= B[WIDTH-1];
                        d_sr <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    d_sr <= d_nxt;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bout_q <= br_nxt;
                        v_q    <= (amsb != bmsb) && (d_bit != amsb);
                        z_q    <= ~|d_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed and exhaustive checks of serial_borrow_subtractor at WIDTH=4.
module tb_serial_borrow_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         Bin, Start, Ack;
    logic         Ready, Valid, Bout, V, Z;
    logic [W-1:0] Diff;

    int errors = 0;
    int checks = 0;

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Start (Start),
        .Ready (Ready),
        .Diff  (Diff),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z),
        .Valid (Valid),
        .Ack   (Ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request (Ready must be high at the current negedge) and wait for Valid.
    // lat is the number of edges after the accepting edge at which Valid is seen.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat);
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        A = ~a; B = ~b; Bin = ~bin;   // operands must not matter after accept
        lat = 0;
        while (!Valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full operation with Ack held high: check result, then the return to IDLE.
    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin, input logic [W-1:0] ed, input logic eb,
                      input logic ev, input logic ez);
        int lat;
        Ack = 1'b1;
        chk({tag, ".ready"}, Ready, 1'b1);
        issue(a, b, bin, lat);
        chk({tag, ".lat"},   lat,   W);
        chk({tag, ".valid"}, Valid, 1'b1);
        chk({tag, ".diff"},  Diff,  ed);
        chk({tag, ".bout"},  Bout,  eb);
        chk({tag, ".v"},     V,     ev);
        chk({tag, ".z"},     Z,     ez);
        @(negedge clk);
        chk({tag, ".idle_valid"}, Valid, 1'b0);
        chk({tag, ".idle_ready"}, Ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] hold_d;
        logic         hold_b, hold_v, hold_z;
        logic [W:0]   ref_r;
        logic [W-1:0] rd;
        int           lat;

        rst_n = 1'b0; A = '0; B = '0; Bin = 1'b0; Start = 1'b0; Ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.ready", Ready, 1'b1);
        chk("rst.valid", Valid, 1'b0);
        chk("rst.diff",  Diff,  '0);
        chk("rst.bout",  Bout,  1'b0);
        chk("rst.v",     V,     1'b0);
        chk("rst.z",     Z,     1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors from hand arithmetic.
        op("v1", 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        op("v2", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        op("v3", 4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        op("v4", 4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
        op("v5", 4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        op("v6", 4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        op("v7", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);

        // Backpressure: hold Ack low, results must stay put and Start must be ignored.
        Ack = 1'b0;
        issue(4'b1001, 4'b0011, 1'b0, lat);
        chk("bp.lat",  lat,  W);
        chk("bp.diff", Diff, 4'b0110);
        hold_d = Diff; hold_b = Bout; hold_v = V; hold_z = Z;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                A = 4'b0000; B = 4'b1111; Bin = 1'b1; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
            chk("bp.hold_valid", Valid, 1'b1);
            chk("bp.hold_ready", Ready, 1'b0);
            chk("bp.hold_diff",  Diff,  hold_d);
            chk("bp.hold_flags", {Bout, V, Z}, {hold_b, hold_v, hold_z});
        end
        Start = 1'b0;
        Ack = 1'b1;
        @(negedge clk);
        chk("bp.rel_valid", Valid, 1'b0);
        chk("bp.rel_ready", Ready, 1'b1);
        @(negedge clk);
        chk("bp.no_ghost", Ready, 1'b1);

        // Reset two cycles after accept aborts the operation.
        A = 4'b1100; B = 4'b0001; Bin = 1'b0; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        chk("mid.busy", Ready, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid.valid", Valid, 1'b0);
        chk("mid.ready", Ready, 1'b1);
        chk("mid.diff",  Diff,  '0);
        chk("mid.bout",  Bout,  1'b0);
        rst_n = 1'b1;
        repeat (W + 1) begin
            @(negedge clk);
            chk("mid.no_partial", Valid, 1'b0);
        end
        op("post", 4'b1100, 4'b0001, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep against {Bout, Diff} = A - B - Bin.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    ref_r = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
                    rd    = ref_r[W-1:0];
                    op("sweep", 4'(ai), 4'(bi), 1'(ci), rd, ref_r[W],
                       (ai[3] != bi[3]) && (rd[3] != ai[3]), rd == '0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Bit-serial subtractor. Computes Diff = A - B - Bin one bit per clock, LSB first, reusing a single full-subtractor cell, so the borrow ripples in time rather than in space.
- It is the inverse-operation counterpart to the combinational ripple-carry adder, intended for area-constrained datapaths.
- Operands are taken through a ready/valid input handshake; the result is held under a valid/ready output handshake until consumed.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  minuend, sampled on accept.
- B  input  WIDTH  subtrahend, sampled on accept.
- Bin  input  1  borrow-in, sampled on accept.
- Start  input  1  request; accepted on the edge where Start=1 and Ready=1.
- Ready  output  1  high only in IDLE.
- Diff  output  WIDTH  result, valid while Valid=1.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
- V  output  1  signed overflow: (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
- Z  output  1  Diff == 0.
- Valid  output  1  result available.
- Ack  input  1  consumer accepts the result when Valid=1 and Ack=1.

Behaviour:
- States are IDLE, SHIFT and DONE. Reset state is IDLE.
- Reset values: Ready=1, Valid=0, Diff=0, Bout=0, V=0, Z=0. Internal shift registers, bit counter and borrow flop are all cleared.
- IDLE, on Start=1:
  - latch A, B and Bin into operand shift registers and the borrow flop;
  - counter=0; go to SHIFT.
- SHIFT, each edge:
  - d = a0 ^ b0 ^ br;
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br);
  - shift d into the Diff register from the MSB side; shift the operands right; counter++.
  - After the edge with counter == WIDTH-1, go to DONE.
- Latency: Valid rises exactly WIDTH cycles after the accepting edge (4 cycles at the default width).
- On entering DONE:
  - Bout = final borrow;
  - V is computed from the latched A/B MSBs and the Diff MSB;
  - Z = ~|Diff.
- DONE:
  - Valid=1; Diff, Bout, V and Z are held stable until Ack=1.
  - On Ack=1, go to IDLE: Valid=0 and Ready=1 on the next cycle.
- Start is ignored outside IDLE. A Start in the same cycle as Ack in DONE is not accepted; back-to-back issue costs one IDLE cycle.
- Input operands may change freely after the accept edge without affecting the result.
- Reset asserted in any state, including mid-SHIFT:
  - the operation is aborted on that edge;
  - all outputs return to their reset values;
  - no partial result is ever presented.
- Arithmetic is modulo 2^WIDTH. Bin=1 with A=B gives Diff = all-ones and Bout=1.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - counter width constant $clog2(WIDTH).
- One natural sub-module: full_subtractor_cell, combinational. Inputs a, b, bin; outputs d, bout.
- FSM, counter and shift registers live in the top module.

Test Plan:
- A=0001, B=0010, Bin=0, Ack held 1 -> after 4 cycles Valid=1, Diff=1111, Bout=1, V=0, Z=0.
- A=0101, B=0011, Bin=0 -> Diff=0010, Bout=0, V=0, Z=0. Then A=1111, B=0001 -> Diff=1110, Bout=0, V=0.
- A=1010, B=0101, Bin=1 -> Diff=0100, Bout=0, V=1, Z=0. A=0110, B=0110, Bin=0 -> Diff=0000, Z=1, Bout=0.
- Backpressure:
  - drive Ack=0 for 10 cycles after Valid; outputs must stay stable and Ready=0;
  - a Start pulsed during that window must be ignored;
  - raising Ack must give Valid=0 and Ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 two cycles after accept -> next edge Valid=0, Ready=1, Diff=0. A fresh request then completes correctly.
- Exhaustive sweep at WIDTH=4: all A, B and Bin values against the reference model {Bout, Diff} = A - B - Bin. Check V and Z on every result.
